stream_gather_ctrl: RTL and testbench
=====================================

Name: stream_gather_ctrl

Overview:
- Lane-aligning controller for the concatenated multi-link datapath.
- Each input link gets a one-beat holding register.
- When every active link holds a beat, the block emits one N_LINKS*DATA_WIDTH word on a single AXIS master, lane i = link i (link 0 in the LSBs).
- Adds real per-link backpressure, a lane-enable mask, a lag timeout with stale-link report, and a flush.

Parameters:
N_LINKS, 12, number of input links (1..16)
DATA_WIDTH, 8, bits per link beat
TIMEOUT_W, 16, width of timeout counter and limit

Ports:
clk  in  1  clock; all logic on the rising edge
rstn  in  1  asynchronous active-low reset
s_tdata  in  N_LINKS*DATA_WIDTH  packed link data, link i at [i*DATA_WIDTH +: DATA_WIDTH]
s_tvalid  in  N_LINKS  per-link valid
s_tready  out  N_LINKS  per-link ready
link_enable  in  N_LINKS  requested active-lane mask
timeout_limit  in  TIMEOUT_W  collect-cycle limit; 0 disables timeout
flush  in  1  synchronous pulse; discards all held beats
clear_flag  in  1  synchronous pulse; clears timeout_flag and stale_links
m_tdata  out  N_LINKS*DATA_WIDTH  gathered word
m_tvalid  out  1  output valid
m_tready  in  1  output ready
active_mask  out  N_LINKS  mask currently in force
timeout_flag  out  1  sticky lag-timeout indicator
stale_links  out  N_LINKS  active links still empty when the timeout fired
word_count  out  32  count of words accepted on the master (wraps)

Behaviour:
- Reset (async assert, sync release) clears:
  - holding full bits, m_tvalid, m_tdata, timeout counter, timeout_flag, stale_links, word_count.
  - active_mask resets to 0; FSM resets to IDLE.
- Per-link handshake:
  - Link i accepts on s_tvalid[i] & s_tready[i] into hold[i]; full[i] is set.
  - Active link: s_tready[i] = ~full[i] | fire (same-cycle refill is allowed).
  - Inactive link: s_tready[i] = 1; beats are dropped. Lane i of m_tdata is 0.
- Output register:
  - all_full = &(full | ~active_mask) and active_mask != 0.
  - fire = all_full & (~m_tvalid | m_tready).
  - On fire: m_tdata is loaded from the holds, m_tvalid is set, and all full bits clear (except refills in the same cycle).
  - m_tvalid clears on m_tready when fire is not asserted.
  - m_tdata is stable while m_tvalid & ~m_tready.
  - Latency: last missing beat accepted at cycle t -> m_tvalid at t+1. Sustained throughput is 1 word/cycle.
- FSM:
  - IDLE: no full bits and m_tvalid = 0. active_mask <= link_enable every cycle. Go to COLLECT on any active-link accept.
  - COLLECT: the counter increments each cycle without fire; it resets to 0 on fire.
    - On fire with no refill -> IDLE.
    - When counter == timeout_limit and limit != 0 -> TIMEOUT. On that transition: timeout_flag <= 1, stale_links <= active_mask & ~full.
  - TIMEOUT: keeps collecting normally. fire -> COLLECT or IDLE (same rule). The flag stays set.
- link_enable changes outside IDLE are ignored until the next IDLE. This means the mask never changes while a partial word is held.
- flush:
  - Clears full bits and the counter, and forces IDLE next cycle.
  - Does not drop a word already in the output register.
  - Takes priority over fire and over accepts in the same cycle; s_tready is forced to 0 during flush.
- clear_flag clears timeout_flag and stale_links. If a timeout fires in the same cycle, the set wins.
- word_count increments on m_tvalid & m_tready and wraps at 2^32.
- active_mask == 0: never fires, all s_tready = 1, FSM stays in IDLE.

Test Plan:
1. Reset with N_LINKS=12, enable=0xFFF; all links present beat 0x10+i in the same cycle -> m_tvalid one cycle later, m_tdata = {0x1B,...,0x11,0x10}, word_count=1 after m_tready.
2. Links 0-10 valid at cycle 0, link 11 valid at cycle 5 -> links 0-10 see s_tready=0 from cycle 1; m_tvalid at cycle 6; no beat lost or duplicated.
3. Continuous valid on all links with m_tready=1 for 100 cycles -> 100 words, 1 per cycle. Hold m_tready=0 for 3 cycles mid-stream -> m_tdata stable and all s_tready=0 after refill.
4. enable=0x00F, link 5 toggling valid -> link 5 always ready, lane 5 = 0x00, words formed from links 0-3 only. Change enable mid-collect -> active_mask unchanged until IDLE.
5. timeout_limit=8, link 2 never valid -> timeout_flag=1 after 8 collect cycles, stale_links=0x004. Then link 2 arrives -> word emitted, flag still 1. clear_flag -> flag=0, stale_links=0.
6. Links 0-5 held, then flush -> full cleared, IDLE, no word emitted. Assert rstn=0 while m_tvalid=1 -> m_tvalid=0 immediately and word_count=0.

Source files
------------

// File: rtl/stream_gather_ctrl.sv
// Purpose : gathers one beat from every active input link into a single wide
//           word (lane i = link i, link 0 in the LSBs) on one AXIS-style master.
// Latency : last missing beat captured at edge t -> m_tvalid high after edge t+1;
//           sustained throughput is one word per cycle.
// Backpr. : per-link s_tready drops once that link's holding register is full
//           and the word cannot fire; inactive links are always ready (beats dropped);
//           flush forces every s_tready low for its cycle.
//
// Ports:
//   clk, rstn        clock (rising edge) and asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready   packed per-link input streams
//   link_enable      requested lane mask, sampled only while IDLE
//   timeout_limit    collect-cycle limit for the lag timeout (0 = disabled)
//   flush            one-cycle pulse: discard all partially gathered beats
//   clear_flag       one-cycle pulse: clear timeout_flag and stale_links
//   m_tdata/m_tvalid/m_tready   gathered output word stream
//   active_mask      lane mask currently in force
//   timeout_flag     sticky lag-timeout indicator
//   stale_links      active links still empty when the timeout fired
//   word_count       words accepted on the master (wraps at 2^32)

module stream_gather_ctrl #(
  parameter int N_LINKS    = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [N_LINKS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [N_LINKS-1:0]              s_tvalid,
  output logic [N_LINKS-1:0]              s_tready,
  input  logic [N_LINKS-1:0]              link_enable,
  input  logic [TIMEOUT_W-1:0]            timeout_limit,
  input  logic                            flush,
  input  logic                            clear_flag,
  output logic [N_LINKS*DATA_WIDTH-1:0]   m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [N_LINKS-1:0]              active_mask,
  output logic                            timeout_flag,
  output logic [N_LINKS-1:0]              stale_links,
  output logic [31:0]                     word_count
);

  localparam int WORD_W = N_LINKS * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t                 state;
  logic [N_LINKS-1:0]     full;
  logic [WORD_W-1:0]      hold;
  logic [TIMEOUT_W-1:0]   lag_cnt;

  logic                   all_full;
  logic                   fire;
  logic [N_LINKS-1:0]     accept;
  logic                   refill;
  logic                   to_timeout;
  logic [WORD_W-1:0]      lane_mask;
  logic [WORD_W-1:0]      gathered;

  // ---------------------------------------------------------------------------
  // Handshake and fire decision
  // ---------------------------------------------------------------------------
  always_comb begin
    all_full = (&(full | ~active_mask)) & (|active_mask);
    // flush beats fire so that a half-cleared word can never be emitted
    fire     = all_full & (~m_tvalid | m_tready) & ~flush;

    s_tready = '1;
    for (int i = 0; i < N_LINKS; i++) begin
      if (flush) begin
        s_tready[i] = 1'b0;
      end else if (active_mask[i]) begin
        // a firing word frees its slot this cycle, so the link may refill now
        s_tready[i] = ~full[i] | fire;
      end else begin
        s_tready[i] = 1'b1;
      end
    end

    // inactive links handshake but their beats are never stored
    accept = s_tvalid & s_tready & active_mask;
    refill = |accept;

    to_timeout = (state == COLLECT) & ~fire & ~flush &
                 (timeout_limit != '0) & (lag_cnt == timeout_limit);

    // a lane that was active in an earlier word may still hold old data,
    // so inactive lanes are zeroed on load rather than trusting the hold
    lane_mask = '0;
    for (int i = 0; i < N_LINKS; i++) begin
      lane_mask[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{active_mask[i]}};
    end
    gathered = hold & lane_mask;
  end

  // ---------------------------------------------------------------------------
  // Holding registers and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold       <= '0;
      full       <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      word_count <= '0;
    end else begin
      for (int i = 0; i < N_LINKS; i++) begin
        if (accept[i]) begin
          hold[i*DATA_WIDTH +: DATA_WIDTH] <= s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      if (flush) begin
        full <= '0;
      end else if (fire) begin
        // the fired word empties every slot; only same-cycle refills remain
        full <= accept;
      end else begin
        full <= full | accept;
      end

      // flush leaves the output register alone: a formed word is never dropped
      if (fire) begin
        m_tvalid <= 1'b1;
        m_tdata  <= gathered;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (m_tvalid && m_tready) begin
        word_count <= word_count + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: lane mask, lag counter, timeout reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      lag_cnt      <= '0;
      active_mask  <= '0;
      timeout_flag <= 1'b0;
      stale_links  <= '0;
    end else begin
      // a timeout in the same cycle as clear_flag wins
      if (to_timeout) begin
        timeout_flag <= 1'b1;
        stale_links  <= active_mask & ~full;
      end else if (clear_flag) begin
        timeout_flag <= 1'b0;
        stale_links  <= '0;
      end

      if (flush) begin
        state   <= IDLE;
        lag_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            lag_cnt <= '0;
            if (refill) begin
              // keep the mask that admitted this beat; it is frozen until the
              // partial word is either emitted or flushed
              state <= COLLECT;
            end else begin
              active_mask <= link_enable;
            end
          end

          COLLECT, TIMEOUT: begin
            if (fire) begin
              lag_cnt <= '0;
              state   <= refill ? COLLECT : IDLE;
            end else begin
              // saturate so a long stall in TIMEOUT cannot wrap back to 0
              if (lag_cnt != '1) begin
                lag_cnt <= lag_cnt + TIMEOUT_W'(1);
              end
              if (to_timeout) begin
                state <= TIMEOUT;
              end
            end
          end

          default: begin
            state   <= IDLE;
            lag_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_gather_ctrl.sv
// Directed bench for stream_gather_ctrl with N_LINKS=12, DATA_WIDTH=8.
// Edge numbering inside each task: E0 is the first rising edge after stimulus
// is applied; outputs are sampled 1 time unit after an edge.

module tb_stream_gather_ctrl;

  localparam int N  = 12;
  localparam int W  = 8;
  localparam int TW = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N*W-1:0]    s_tdata;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tready;
  logic [N-1:0]      link_enable;
  logic [TW-1:0]     timeout_limit;
  logic              flush;
  logic              clear_flag;
  logic [N*W-1:0]    m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [N-1:0]      active_mask;
  logic              timeout_flag;
  logic [N-1:0]      stale_links;
  logic [31:0]       word_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  stream_gather_ctrl #(.N_LINKS(N), .DATA_WIDTH(W), .TIMEOUT_W(TW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .link_enable   (link_enable),
    .timeout_limit (timeout_limit),
    .flush         (flush),
    .clear_flag    (clear_flag),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .active_mask   (active_mask),
    .timeout_flag  (timeout_flag),
    .stale_links   (stale_links),
    .word_count    (word_count)
  );

  // stimulus generators: lane i = base + i, or every lane = v
  function automatic logic [N*W-1:0] lanes_seq(input logic [7:0] base);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [N*W-1:0] lanes_all(input logic [7:0] v);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_tdata = '0; s_tvalid = '0; link_enable = '0;
    timeout_limit = '0; flush = 1'b0; clear_flag = 1'b0; m_tready = 1'b0;
    #12;
    tests_run++;
    if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    tests_run++;
    if (m_tdata !== '0) begin tests_failed++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    tests_run++;
    if (word_count !== 32'd0 || timeout_flag !== 1'b0 || stale_links !== 12'h000)
      begin tests_failed++; $display("FAIL reset_status: wc %0d flag %b stale %h want 0/0/000", word_count, timeout_flag, stale_links); end
    tests_run++;
    if (active_mask !== 12'h000 || s_tready !== 12'hFFF)
      begin tests_failed++; $display("FAIL reset_mask: mask %h ready %h want 000/FFF", active_mask, s_tready); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_all_links();
    link_enable = 12'hFFF;
    tick();
    tests_run++;
    if (active_mask !== 12'hFFF) begin tests_failed++; $display("FAIL tp1_mask: got %h want FFF", active_mask); end
    s_tvalid = 12'hFFF; s_tdata = lanes_seq(8'h10);
    #1;
    tests_run++;
    if (s_tready !== 12'hFFF) begin tests_failed++; $display("FAIL tp1_ready: got %h want FFF", s_tready); end
    tick();                       // E0: all beats captured
    s_tvalid = '0;
    tests_run++;
    if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL tp1_early: got %b want 0", m_tvalid); end
    tick();                       // E1: word fires
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h1B1A19181716151413121110)
      begin tests_failed++; $display("FAIL tp1_word: vld %b dat %h want 1/1B1A19181716151413121110", m_tvalid, m_tdata); end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tests_run++;
    if (word_count !== 32'd1 || m_tvalid !== 1'b0)
      begin tests_failed++; $display("FAIL tp1_count: wc %0d vld %b want 1/0", word_count, m_tvalid); end
  endtask

  task automatic test_skew();
    s_tvalid = 12'h7FF; s_tdata = lanes_seq(8'h20);
    tick();                       // E0: links 0-10 captured
    s_tdata = lanes_seq(8'h40);   // links 0-10 now offer their next beat
    #1;
    tests_run++;
    if (s_tready !== 12'h800) begin tests_failed++; $display("FAIL tp2_ready_c1: got %h want 800", s_tready); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests_run++;
      if (s_tready !== 12'h800 || m_tvalid !== 1'b0)
        begin tests_failed++; $display("FAIL tp2_wait: cyc %0d ready %h vld %b want 800/0", c, s_tready, m_tvalid); end
    end
    s_tvalid = 12'hFFF;
    s_tdata[11*W +: W] = 8'h2B;
    tick();                       // E5: link 11 captured
    s_tvalid = 12'h7FF;
    #1;
    tests_run++;
    if (s_tready !== 12'hFFF || m_tvalid !== 1'b0)
      begin tests_failed++; $display("FAIL tp2_fire_cyc: ready %h vld %b want FFF/0", s_tready, m_tvalid); end
    tick();                       // E6: fire + refill of links 0-10
    s_tvalid = '0;
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h2B2A29282726252423222120)
      begin tests_failed++; $display("FAIL tp2_word1: vld %b dat %h want 1/2B2A29282726252423222120", m_tvalid, m_tdata); end
    tests_run++;
    if (s_tready !== 12'h800) begin tests_failed++; $display("FAIL tp2_refilled: got %h want 800", s_tready); end
    m_tready = 1'b1;
    tick();
    tests_run++;
    if (word_count !== 32'd2 || m_tvalid !== 1'b0)
      begin tests_failed++; $display("FAIL tp2_count: wc %0d vld %b want 2/0", word_count, m_tvalid); end
    s_tvalid = 12'h800; s_tdata[11*W +: W] = 8'h4B;
    tick();
    s_tvalid = '0;
    tick();
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h4B4A49484746454443424140)
      begin tests_failed++; $display("FAIL tp2_word2: vld %b dat %h want 1/4B4A49484746454443424140", m_tvalid, m_tdata); end
    tick();
    m_tready = 1'b0;
    tests_run++;
    if (word_count !== 32'd3) begin tests_failed++; $display("FAIL tp2_count2: got %0d want 3", word_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]     seq;
    logic [7:0]     expw;
    int             got;
    logic           adv;
    logic [N*W-1:0] stall_dat;
    seq = 8'd0; expw = 8'd0; got = 0; stall_dat = '0;
    s_tvalid = 12'hFFF; s_tdata = lanes_all(seq);
    for (int cyc = 0; cyc < 105; cyc++) begin
      m_tready = !(cyc >= 50 && cyc < 53);
      #1;
      if (m_tvalid && m_tready) begin
        tests_run++;
        if (m_tdata !== lanes_all(expw))
          begin tests_failed++; $display("FAIL tp3_data: cyc %0d got %h want lanes of %h", cyc, m_tdata, expw); end
        expw++; got++;
      end
      if (cyc == 50) begin
        stall_dat = m_tdata;
        tests_run++;
        if (m_tvalid !== 1'b1 || m_tdata !== lanes_all(8'd48))
          begin tests_failed++; $display("FAIL tp3_stall_word: vld %b dat %h want 1/lanes of 30", m_tvalid, m_tdata); end
      end
      if (cyc >= 50 && cyc < 53) begin
        tests_run++;
        if (s_tready !== 12'h000) begin tests_failed++; $display("FAIL tp3_stall_ready: cyc %0d got %h want 000", cyc, s_tready); end
      end
      if (cyc > 50 && cyc < 53) begin
        tests_run++;
        if (m_tdata !== stall_dat) begin tests_failed++; $display("FAIL tp3_stall_stable: cyc %0d got %h want %h", cyc, m_tdata, stall_dat); end
      end
      adv = s_tready[0];
      tick();
      if (adv) begin seq++; s_tdata = lanes_all(seq); end
    end
    tests_run++;
    if (got !== 100) begin tests_failed++; $display("FAIL tp3_rate: got %0d words want 100", got); end
    s_tvalid = '0; m_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (m_tvalid && m_tready) begin
        tests_run++;
        if (m_tdata !== lanes_all(expw))
          begin tests_failed++; $display("FAIL tp3_drain: got %h want lanes of %h", m_tdata, expw); end
        expw++;
      end
      tick();
    end
    m_tready = 1'b0;
    tests_run++;
    if (expw !== 8'd102 || seq !== 8'd102)
      begin tests_failed++; $display("FAIL tp3_lossless: words %0d beats %0d want 102/102", expw, seq); end
    tests_run++;
    if (word_count !== 32'd105) begin tests_failed++; $display("FAIL tp3_count: got %0d want 105", word_count); end
  endtask

  task automatic test_mask();
    link_enable = 12'h00F;
    tick();
    tests_run++;
    if (active_mask !== 12'h00F) begin tests_failed++; $display("FAIL tp4_mask: got %h want 00F", active_mask); end
    s_tvalid = 12'h023; s_tdata = lanes_seq(8'h50);
    #1;
    tests_run++;
    if (s_tready !== 12'hFFF) begin tests_failed++; $display("FAIL tp4_ready0: got %h want FFF", s_tready); end
    tick();                       // E0: links 0,1 captured, link 5 dropped
    link_enable = 12'hFFF; s_tvalid = 12'h00C;
    #1;
    tests_run++;
    if (s_tready !== 12'hFFC || active_mask !== 12'h00F)
      begin tests_failed++; $display("FAIL tp4_partial: ready %h mask %h want FFC/00F", s_tready, active_mask); end
    tick();                       // E1: links 2,3 captured
    s_tvalid = 12'h020;
    #1;
    tests_run++;
    if (s_tready !== 12'hFFF || active_mask !== 12'h00F)
      begin tests_failed++; $display("FAIL tp4_fire_cyc: ready %h mask %h want FFF/00F", s_tready, active_mask); end
    tick();                       // E2: fire
    s_tvalid = '0;
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h000000000000000053525150)
      begin tests_failed++; $display("FAIL tp4_word: vld %b dat %h want 1/000000000000000053525150", m_tvalid, m_tdata); end
    tick();                       // E3: IDLE picks up the new enable
    tests_run++;
    if (active_mask !== 12'hFFF) begin tests_failed++; $display("FAIL tp4_mask_idle: got %h want FFF", active_mask); end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tests_run++;
    if (word_count !== 32'd106) begin tests_failed++; $display("FAIL tp4_count: got %0d want 106", word_count); end
  endtask

  task automatic test_timeout();
    timeout_limit = 16'd8;
    s_tvalid = 12'hFFB; s_tdata = lanes_seq(8'h60);
    tick();                       // E0: enter COLLECT, counter 0
    s_tvalid = '0;
    repeat (8) tick();            // E8: counter reaches 8
    tests_run++;
    if (timeout_flag !== 1'b0) begin tests_failed++; $display("FAIL tp5_early: got %b want 0", timeout_flag); end
    tick();                       // E9: timeout taken
    tests_run++;
    if (timeout_flag !== 1'b1 || stale_links !== 12'h004)
      begin tests_failed++; $display("FAIL tp5_flag: flag %b stale %h want 1/004", timeout_flag, stale_links); end
    s_tvalid = 12'h004;
    tick();
    s_tvalid = '0;
    tick();
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h6B6A69686766656463626160 || timeout_flag !== 1'b1)
      begin tests_failed++; $display("FAIL tp5_word: vld %b dat %h flag %b want 1/6B6A69686766656463626160/1", m_tvalid, m_tdata, timeout_flag); end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tests_run++;
    if (word_count !== 32'd107) begin tests_failed++; $display("FAIL tp5_count: got %0d want 107", word_count); end
    clear_flag = 1'b1;
    tick();
    clear_flag = 1'b0;
    tests_run++;
    if (timeout_flag !== 1'b0 || stale_links !== 12'h000)
      begin tests_failed++; $display("FAIL tp5_clear: flag %b stale %h want 0/000", timeout_flag, stale_links); end
    timeout_limit = '0;
  endtask

  task automatic test_flush();
    s_tvalid = 12'hFFF; s_tdata = lanes_seq(8'h70);
    tick();
    s_tvalid = '0;
    tick();
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h7B7A79787776757473727170)
      begin tests_failed++; $display("FAIL tp6_word: vld %b dat %h want 1/7B7A79787776757473727170", m_tvalid, m_tdata); end
    s_tvalid = 12'h03F; s_tdata = lanes_seq(8'h80);
    tick();
    s_tvalid = '0;
    repeat (20) tick();
    tests_run++;
    if (timeout_flag !== 1'b0 || s_tready !== 12'hFC0)
      begin tests_failed++; $display("FAIL tp6_held: flag %b ready %h want 0/FC0", timeout_flag, s_tready); end
    flush = 1'b1;
    #1;
    tests_run++;
    if (s_tready !== 12'h000) begin tests_failed++; $display("FAIL tp6_flush_ready: got %h want 000", s_tready); end
    tick();
    flush = 1'b0;
    #1;
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h7B7A79787776757473727170)
      begin tests_failed++; $display("FAIL tp6_keep_out: vld %b dat %h want 1/7B7A79787776757473727170", m_tvalid, m_tdata); end
    tests_run++;
    if (s_tready !== 12'hFFF) begin tests_failed++; $display("FAIL tp6_cleared: got %h want FFF", s_tready); end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tests_run++;
    if (word_count !== 32'd108 || m_tvalid !== 1'b0)
      begin tests_failed++; $display("FAIL tp6_count: wc %0d vld %b want 108/0", word_count, m_tvalid); end
    s_tvalid = 12'hFFF; s_tdata = lanes_seq(8'h90);
    tick();
    s_tvalid = '0;
    tick();
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h9B9A99989796959493929190)
      begin tests_failed++; $display("FAIL tp6_after: vld %b dat %h want 1/9B9A99989796959493929190", m_tvalid, m_tdata); end
  endtask

  task automatic test_async_reset();
    rstn = 1'b0;
    #1;
    tests_run++;
    if (m_tvalid !== 1'b0 || word_count !== 32'd0 || active_mask !== 12'h000)
      begin tests_failed++; $display("FAIL tp6_arst: vld %b wc %0d mask %h want 0/0/000", m_tvalid, word_count, active_mask); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_all_links();
    test_skew();
    test_back_to_back();
    test_mask();
    test_timeout();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
